// File: rtl/maxpool2_pkg.sv
// maxpool2_pkg: shared FSM states and frame-size helpers for the maxpool-2 frame sequencer.
package maxpool2_pkg;
    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, FLUSH, DONE} state_e;
    function automatic int n_in(input int w, input int h);
        return w * h;
    endfunction
    function automatic int n_out(input int w, input int h);
        return (w / 2) * (h / 2);
    endfunction
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/maxpool2_out_fifo.sv
// maxpool2_out_fifo: first-word fall-through FIFO with occupancy; a full FIFO accepts a write only alongside a read.
module maxpool2_out_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          rd, wr;
    assign empty_o   = count_q == '0;
    assign count_o   = count_q;
    assign rd        = rd_en_i & ~empty_o;
    assign wr        = wr_en_i & ((count_q != (AW+1)'(DEPTH)) | rd);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q  <= count_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/maxpool2_frame_ctrl.sv
// maxpool2_frame_ctrl: sequences one frame into the 16-channel maxpool-2 layer and buffers pooled beats.
// Define MAXPOOL2_FRAME_CHECK_EN to build the sticky err checker.
module maxpool2_frame_ctrl
    import maxpool2_pkg::*;
#(
    parameter int WIDTH      = 11,
    parameter int HEIGHT     = 11,
    parameter int CH         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SLACK      = 2,
    parameter int DRAIN_MAX  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          src_valid,
    input  logic [CH-1:0] src_data,
    output logic          src_ready,
    output logic          pool_valid_in,
    output logic [CH-1:0] pool_pixel,
    input  logic          pool_valid_out,
    input  logic [CH-1:0] pool_data,
    output logic          dst_valid,
    output logic [CH-1:0] dst_data,
    output logic          dst_last,
    input  logic          dst_ready,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);
    localparam int NI = n_in(WIDTH, HEIGHT);
    localparam int NO = n_out(WIDTH, HEIGHT);
    localparam int IW = cnt_w(NI);
    localparam int OW = cnt_w(NO);
    localparam int DW = cnt_w(DRAIN_MAX);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] RDY_MAX = (AW+1)'(FIFO_DEPTH - SLACK);
    state_e        state_q;
    logic [IW-1:0] in_cnt_q;
    logic [OW-1:0] out_cnt_q;
    logic [DW-1:0] drain_cnt_q;
    logic          pool_valid_in_q, frame_done_q;
    logic [CH-1:0] pool_pixel_q;
    logic [AW:0]   occ;
    logic [CH:0]   head;
    logic          empty, src_hs, out_full, take;
    assign src_ready     = (state_q == STREAM) && (occ <= RDY_MAX);
    assign src_hs        = src_valid & src_ready;
    assign out_full      = out_cnt_q == OW'(NO);
    // Pooled beats are only kept while the frame is live and not yet complete.
    assign take          = pool_valid_out & ((state_q == STREAM) | (state_q == DRAIN)) & ~out_full;
    assign pool_valid_in = pool_valid_in_q;
    assign pool_pixel    = pool_pixel_q;
    assign busy          = state_q != IDLE;
    assign frame_done    = frame_done_q;
    assign dst_valid     = ~empty;
    assign dst_data      = head[CH-1:0];
    assign dst_last      = dst_valid & head[CH];
    maxpool2_out_fifo #(.W(CH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (take),
        .wr_data_i ({out_cnt_q == OW'(NO - 1), pool_data}),
        .rd_en_i   (dst_ready),
        .rd_data_o (head),
        .empty_o   (empty),
        .count_o   (occ)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            in_cnt_q        <= '0;
            out_cnt_q       <= '0;
            drain_cnt_q     <= '0;
            pool_valid_in_q <= 1'b0;
            pool_pixel_q    <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            pool_valid_in_q <= src_hs;
            if (src_hs) pool_pixel_q <= src_data;
            frame_done_q <= 1'b0;
            if (take) out_cnt_q <= out_cnt_q + 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    state_q     <= STREAM;
                    in_cnt_q    <= '0;
                    out_cnt_q   <= '0;
                    drain_cnt_q <= '0;
                end
                STREAM: if (src_hs) begin
                    in_cnt_q <= in_cnt_q + 1'b1;
                    if (in_cnt_q == IW'(NI - 1)) state_q <= DRAIN;
                end
                DRAIN: begin
                    drain_cnt_q <= pool_valid_out ? '0 : drain_cnt_q + 1'b1;
                    if (out_full || drain_cnt_q == DW'(DRAIN_MAX - 1)) state_q <= FLUSH;
                end
                FLUSH: if (empty) begin
                    state_q      <= DONE;
                    frame_done_q <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef MAXPOOL2_FRAME_CHECK_EN
    logic err_q, drop, extra, timeout;
    assign drop    = take & (occ == (AW+1)'(FIFO_DEPTH)) & ~dst_ready;
    assign extra   = pool_valid_out & ~take;
    assign timeout = (state_q == DRAIN) & (drain_cnt_q == DW'(DRAIN_MAX - 1)) & ~out_full;
    assign err     = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | drop | extra | timeout;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_maxpool2_frame_ctrl.sv
// tb_maxpool2_frame_ctrl: random frames through a behavioural 2x2 max-pool model, scoreboarded at dst.
module tb_maxpool2_frame_ctrl;
    localparam int W = 11, H = 11, CH = 16, NI = W * H, NO = (W / 2) * (H / 2);
    logic clk = 0, rst = 1, start = 0, src_valid = 0, pool_valid_out = 0, dst_ready = 1;
    logic src_ready, pool_valid_in, dst_valid, dst_last, busy, frame_done, err;
    logic [CH-1:0] src_data = '0, pool_data = '0, pool_pixel, dst_data;
    typedef struct packed {logic [CH-1:0] d; logic l;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    logic [CH-1:0] frame [NI];
    int errors = 0, checks = 0;
    int in_hs = 0, pvi_cnt = 0, fd_cnt = 0, dst_cnt = 0, occ = 0;
    bit rdy_low = 0, withhold = 0, inject = 0, inj_now = 0, exp_err = 0, mac_err = 0;
    always #5 clk = ~clk;

    maxpool2_frame_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .pool_valid_in(pool_valid_in), .pool_pixel(pool_pixel),
        .pool_valid_out(pool_valid_out), .pool_data(pool_data), .dst_valid(dst_valid),
        .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Pooling layer: ORs each 2x2 window as its bottom-right pixel streams in, one cycle later.
    initial begin : pool_model
        logic [CH-1:0] seen [NI];
        logic [CH-1:0] p;
        int b, r, c, k;
        bit v, extra_pend;
        b = 0;
        extra_pend = 0;
        forever begin
            @(negedge clk);
            v = pool_valid_in;
            p = pool_pixel;
            if (rst) begin
                b = 0;
                extra_pend = 0;
            end
            @(posedge clk);
            #1;
            pool_valid_out = 0;
            inj_now = 0;
            if (v && !rst) begin
                r = b / W;
                c = b % W;
                seen[b] = p;
                if (r % 2 == 1 && c % 2 == 1 && r < 2 * (H / 2) && c < 2 * (W / 2)) begin
                    k = (r / 2) * (W / 2) + c / 2;
                    if (!(withhold && k >= NO - 3)) begin
                        pool_valid_out = 1;
                        pool_data = seen[b] | seen[b - 1] | seen[b - W] | seen[b - W - 1];
                        if (inject && k == NO - 1) extra_pend = 1;
                    end
                end
                b = (b == NI - 1) ? 0 : b + 1;
            end
            if (!pool_valid_out && extra_pend) begin
                pool_valid_out = 1;
                pool_data = CH'($urandom);
                inj_now = 1;
                extra_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pool_valid_in) pvi_cnt++;
            if (frame_done) fd_cnt++;
            if (busy && in_hs < NI) begin
                check("src_ready_vs_occupancy", src_ready, occ <= 2);
                if (!src_ready) rdy_low = 1;
            end
            if (dst_valid && dst_ready) begin
                dst_cnt++;
                if (exp_q.size() == 0) check("dst_unexpected_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("dst_data", dst_data, e.d);
                    check("dst_last", dst_last, e.l);
                end
            end
            occ = occ + ((pool_valid_out && !inj_now) ? 1 : 0) - ((dst_valid && dst_ready) ? 1 : 0);
        end
    end

    task automatic do_reset();
        rst = 1;
        src_valid = 0;
        start = 0;
        dst_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        occ = 0;
        in_hs = 0;
        rst = 0;
    endtask

    task automatic run_frame(input int stall_at, input int start_at, input int rst_at, input bit rnd);
        int i, cyc, stall;
        bit hs;
        logic [CH-1:0] d;
        i = 0;
        cyc = 0;
        stall = 0;
        for (int k = 0; k < NI; k++) frame[k] = CH'($urandom & $urandom & $urandom);
        for (int ro = 0; ro < H / 2; ro++)
            for (int co = 0; co < W / 2; co++) begin
                d = frame[2*ro*W + 2*co] | frame[2*ro*W + 2*co + 1]
                  | frame[(2*ro+1)*W + 2*co] | frame[(2*ro+1)*W + 2*co + 1];
                if (!(withhold && ro * (W / 2) + co >= NO - 3))
                    exp_q.push_back('{d: d, l: (ro * (W / 2) + co == NO - 1)});
            end
        in_hs = 0;
        pvi_cnt = 0;
        fd_cnt = 0;
        dst_cnt = 0;
        @(posedge clk); #1; start = 1;
        @(posedge clk); #1; start = 0;
        src_data = frame[0];
        src_valid = 1;
        while (i < NI && cyc < 4000) begin
            @(negedge clk);
            hs = src_valid && src_ready;
            @(posedge clk);
            #1;
            cyc++;
            start = 0;
            if (stall > 0) begin
                stall--;
                if (stall == 0) dst_ready = 1;
            end
            if (hs) begin
                i++;
                in_hs = i;
                if (i == stall_at) begin dst_ready = 0; stall = 40; end
                if (i == start_at) start = 1;
                if (i == rst_at) begin
                    rst = 1;
                    #1;
                    check("reset_outputs_zero", {src_ready, pool_valid_in, pool_pixel, dst_valid,
                          dst_data, dst_last, busy, frame_done, err}, '0);
                    do_reset();
                    return;
                end
            end
            src_data = frame[i % NI];
            src_valid = (i < NI) && (!rnd || $urandom_range(0, 3) != 0);
        end
        src_valid = 0;
        start = 0;
        if (stall > 0) begin repeat (stall) @(posedge clk); #1; dst_ready = 1; end
        if (i < NI) check("src_beats_timeout", i, NI);
        cyc = 0;
        while (fd_cnt == 0 && cyc < 1000) begin @(posedge clk); cyc++; end
        check("frame_done_seen", fd_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("pool_valid_in_count", pvi_cnt, NI);
        check("dst_beat_count", dst_cnt, withhold ? NO - 3 : NO);
        check("scoreboard_empty", exp_q.size(), 0);
        check("frame_done_once", fd_cnt, 1);
        check("err_flag", err, exp_err);
        check("busy_after_frame", busy, 0);
    endtask

    initial begin
`ifdef MAXPOOL2_FRAME_CHECK_EN
        mac_err = 1;
`endif
        #1;
        check("reset_outputs_initial", {src_ready, pool_valid_in, pool_pixel, dst_valid,
              dst_data, dst_last, busy, frame_done, err}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        run_frame(0, 0, 0, 0);
        rdy_low = 0;
        run_frame(20, 0, 0, 1);
        check("src_ready_dropped_in_stall", rdy_low, 1);
        run_frame(0, 50, 0, 1);
        run_frame(0, 0, 60, 0);
        run_frame(0, 0, 0, 0);
        withhold = 1;
        exp_err = mac_err;
        run_frame(0, 0, 0, 1);
        withhold = 0;
        do_reset();
        check("err_cleared_by_reset", err, 0);
        inject = 1;
        run_frame(0, 0, 0, 0);
        inject = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/maxpool2_frame_ctrl.md
# maxpool2_frame_ctrl

Frame sequencer for the 16-channel second max-pooling stage. It pulls one WIDTH×HEIGHT frame of 1-bit-per-channel pixels from the upstream producer with a valid/ready handshake and drives the pooling layer's non-stallable `valid_in` stream. It collects the pooled outputs into a small output FIFO and presents them to the next layer with valid/ready/last. It sits between the conv-2 output buffer and the fully-connected input.

## Interface
- `WIDTH`, 11, input frame columns
- `HEIGHT`, 11, input frame rows
- `CH`, 16, channel count (bits per beat)
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥4)
- `SLACK`, 2, FIFO entries kept free before an input beat is issued
- `DRAIN_MAX`, 32, cycles to wait for outstanding pooled outputs after the last input beat

Ports (clock and reset first; one clock, reset is asynchronous and active-high):
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: single-cycle pulse, begins one frame; ignored unless IDLE
- `src_valid` in 1: upstream beat valid
- `src_data` in CH: upstream pixels, bit i = channel i
- `src_ready` out 1: beat accepted when `src_valid & src_ready`
- `pool_valid_in` out 1: to pooling layer `valid_in`
- `pool_pixel` out CH: to pooling layer `pixel_in_1..16` (bit 0 = channel 1)
- `pool_valid_out` in 1: from pooling layer `valid_out_maxpool`
- `pool_data` in CH: from pooling layer `maxpool_out_1..16`
- `dst_valid` out 1: pooled beat available
- `dst_data` out CH: pooled pixels
- `dst_last` out 1: marks the final pooled beat of the frame
- `dst_ready` in 1: downstream accept
- `busy` out 1: high in any state except IDLE
- `frame_done` out 1: one-cycle pulse, frame complete
- `err` out 1: sticky error flag (only with `MAXPOOL2_FRAME_CHECK_EN`)

## Operation
- Frame constants:
  - N_IN = WIDTH·HEIGHT = 121.
  - N_OUT = (WIDTH/2)·(HEIGHT/2), floor division = 25.
- FSM states:
  - IDLE: `start` → STREAM; clear `in_cnt`, `out_cnt`, `drain_cnt`.
  - STREAM:
    - `src_ready` = (FIFO occupancy ≤ FIFO_DEPTH−SLACK).
    - Each handshake increments `in_cnt`.
    - The handshake with `in_cnt` = N_IN−1 → DRAIN.
  - DRAIN:
    - `src_ready` = 0.
    - `drain_cnt` increments every cycle with no `pool_valid_out` and resets to 0 on each `pool_valid_out`.
    - `out_cnt` = N_OUT, or `drain_cnt` = DRAIN_MAX−1 → FLUSH.
  - FLUSH: wait until the FIFO is empty and no output is pending → DONE.
  - DONE: assert `frame_done` for one cycle → IDLE.
- `out_cnt` increments on each `pool_valid_out` accepted in STREAM or DRAIN. It saturates at N_OUT.
- Outputs arriving while `out_cnt` = N_OUT, or in IDLE/FLUSH/DONE, are discarded, not written to the FIFO.
- `dst_last` = `dst_valid` AND the head entry's tag bit. The tag is set on the write with `out_cnt` = N_OUT−1.
- FIFO full plus `pool_valid_out` on the same cycle: the beat is dropped and the FIFO is unchanged.
- Simultaneous FIFO write and read when full: the read frees a slot and the write succeeds.
- `start` while not IDLE is ignored. The pooling layer is never reset by this block, so every frame delivers exactly N_IN beats unless `rst` is asserted.
- Reset mid-frame:
  - All counters, FIFO pointers and the FSM return to IDLE/0 asynchronously.
  - The system reset also clears the pooling layer.

## Timing
- Reset values: `src_ready`, `pool_valid_in`, `pool_pixel`, `dst_valid`, `dst_data`, `dst_last`, `busy`, `frame_done`, `err` all 0.
- `pool_valid_in`/`pool_pixel` are registered: the cycle after a src handshake. `pool_pixel` holds its value when `pool_valid_in` = 0.
- FIFO is first-word fall-through: `dst_valid` rises the cycle after the FIFO write of `pool_valid_out`.
- `busy` rises the cycle after `start`.
- `frame_done` is registered, one cycle after the FLUSH→DONE condition.
- With `dst_ready` tied high, the next `start` is accepted the cycle after `frame_done`.

## Configuration
- `MAXPOOL2_FRAME_CHECK_EN` defined: `err` is set and held until `rst` on any of these:
  - FIFO overflow drop
  - discarded extra output
  - DRAIN exit by timeout with `out_cnt` < N_OUT
- `MAXPOOL2_FRAME_CHECK_EN` undefined: `err` is tied to 0 and no check logic is built. All other behaviour is identical.

## Structure
- Package `maxpool2_pkg`:
  - FSM state enum (IDLE, STREAM, DRAIN, FLUSH, DONE)
  - N_IN/N_OUT localparam functions
  - counter width via $clog2
- Sub-module `maxpool2_out_fifo`: CH+1 bits wide, FIFO_DEPTH entries, first-word fall-through, exposes occupancy.

## Test plan
- 11×11 frame, `src_valid` and `dst_ready` tied high:
  - 121 `pool_valid_in` pulses, 25 `dst` beats.
  - `dst_last` on beat 25.
  - one `frame_done`, `err` = 0.
- `dst_ready` held low for 40 cycles mid-frame:
  - `src_ready` drops once occupancy reaches 3.
  - no drops; all 25 beats arrive in order.
- `start` pulsed during STREAM → ignored; the frame still ends after 121 input beats.
- Model withholds the last 3 outputs:
  - DRAIN exits after 32 idle cycles.
  - `frame_done` pulses.
  - `err` = 1 only with the macro.
- `rst` asserted at input beat 60 → all outputs 0 next edge. A following full frame yields exactly 25 beats.
- Model injects a 26th `pool_valid_out` → not forwarded; `err` = 1 with the macro.
